// File: rtl/mpc_vaddsub_sat_pipe_if.sv
// Start/done handshake and RAM ports of the saturating vector add/sub kernel.
// master: sequencer and RAM side; slave: the kernel.
interface mpc_vaddsub_sat_pipe_if #(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int CW = 5
);
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [1:0]    op_mode;
    logic [AW-1:0] A_address0;
    logic          A_ce0;
    logic [W-1:0]  A_q0;
    logic [AW-1:0] B_address0;
    logic          B_ce0;
    logic [W-1:0]  B_q0;
    logic [AW-1:0] R_address0;
    logic          R_ce0;
    logic          R_we0;
    logic [W-1:0]  R_d0;
    logic [CW-1:0] sat_count;
    logic          sat_any;

    modport master (
        output ap_start, op_mode, A_q0, B_q0,
        input  ap_done, ap_idle, ap_ready,
        input  A_address0, A_ce0, B_address0, B_ce0,
        input  R_address0, R_ce0, R_we0, R_d0,
        input  sat_count, sat_any
    );

    modport slave (
        input  ap_start, op_mode, A_q0, B_q0,
        output ap_done, ap_idle, ap_ready,
        output A_address0, A_ce0, B_address0, B_ce0,
        output R_address0, R_ce0, R_we0, R_d0,
        output sat_count, sat_any
    );
endinterface

// File: rtl/mpc_vaddsub_sat_pipe.sv
// Element-wise saturating A-B / A+B / B-A / copy over two 1-cycle-latency RAMs.
// One element per cycle; the write stage trails the read stage by one cycle.
module mpc_vaddsub_sat_pipe #(
    parameter int N  = 24,
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int CW = 5
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    mpc_vaddsub_sat_pipe_if.slave io
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    mode_q, mode_d;
    logic          wv_q, wv_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [CW-1:0] sat_q, sat_d;

    logic [W:0]   a_x;
    logic [W:0]   b_x;
    logic [W:0]   s_x;
    logic         ovf;
    logic [W-1:0] res;

    always_comb begin
        a_x = {io.A_q0[W-1], io.A_q0};
        b_x = {io.B_q0[W-1], io.B_q0};
        unique case (mode_q)
            2'b00:   s_x = a_x - b_x;
            2'b01:   s_x = a_x + b_x;
            2'b10:   s_x = b_x - a_x;
            default: s_x = a_x;
        endcase
        // Copy keeps the sign-extended operand, so these bits always agree there.
        ovf = s_x[W] ^ s_x[W-1];
        if (!ovf) begin
            res = s_x[W-1:0];
        end else if (s_x[W]) begin
            res = {1'b1, {(W-1){1'b0}}};
        end else begin
            res = {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        wv_d    = 1'b0;
        waddr_d = waddr_q;
        sat_d   = sat_q;
        if (wv_q && ovf) begin
            sat_d = sat_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (io.ap_start) begin
                    mode_d  = io.op_mode;
                    idx_d   = '0;
                    sat_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wv_d    = 1'b1;
                waddr_d = idx_q;
                idx_d   = idx_q + AW'(1);
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 2'b00;
            wv_q    <= 1'b0;
            waddr_q <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            wv_q    <= wv_d;
            waddr_q <= waddr_d;
            sat_q   <= sat_d;
        end
    end

    assign io.A_ce0      = (state_q == S_RUN);
    assign io.B_ce0      = (state_q == S_RUN);
    assign io.A_address0 = idx_q;
    assign io.B_address0 = idx_q;
    assign io.R_ce0      = wv_q;
    assign io.R_we0      = wv_q;
    assign io.R_address0 = waddr_q;
    assign io.R_d0       = res;
    assign io.ap_done    = (state_q == S_DRAIN);
    assign io.ap_ready   = (state_q == S_DRAIN);
    assign io.ap_idle    = (state_q == S_IDLE) && !io.ap_start;
    assign io.sat_count  = sat_q;
    assign io.sat_any    = |sat_q;
endmodule

// File: tb/tb_mpc_vaddsub_sat_pipe.sv
// Randomized bench for mpc_vaddsub_sat_pipe against a saturating-integer model.
// Covers N=24 and N=1 builds side by side.
module tb_mpc_vaddsub_sat_pipe;
    localparam int N  = 24;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int CW = 5;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk;
    logic rst_n;

    mpc_vaddsub_sat_pipe_if #(.W(W), .AW(AW), .CW(CW)) m ();
    mpc_vaddsub_sat_pipe_if #(.W(W), .AW(1), .CW(1)) m1 ();

    mpc_vaddsub_sat_pipe #(.N(N), .W(W), .AW(AW), .CW(CW)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .io       (m)
    );

    mpc_vaddsub_sat_pipe #(.N(1), .W(W), .AW(1), .CW(1)) dut1 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .io       (m1)
    );

    logic [31:0]   amem [N];
    logic [31:0]   bmem [N];
    logic [31:0]   a1;
    logic [31:0]   b1;
    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    int n_chk;
    int n_pass;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (m.A_ce0) m.A_q0 <= amem[m.A_address0];
        if (m.B_ce0) m.B_q0 <= bmem[m.B_address0];
        if (m1.A_ce0) m1.A_q0 <= a1;
        if (m1.B_ce0) m1.B_q0 <= b1;
    end

    always @(negedge clk) begin
        if (m.R_we0 && m.R_ce0) begin
            wa.push_back(m.R_address0);
            wd.push_back(m.R_d0);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] ref_r(input logic [1:0] md,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          output bit sat);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (md)
            2'd0:    r = sa - sb;
            2'd1:    r = sa + sb;
            2'd2:    r = sb - sa;
            default: r = sa;
        endcase
        sat = 1'b0;
        if (r > MAXV) begin
            sat = 1'b1;
            r = MAXV;
        end else if (r < MINV) begin
            sat = 1'b1;
            r = MINV;
        end
        return 32'(r);
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h7fffffff - 32'($urandom_range(0, 255));
            2:       return 32'h80000000 + 32'($urandom_range(0, 255));
            default: return 32'($urandom_range(0, 511)) - 32'd256;
        endcase
    endfunction

    task automatic load_rand();
        for (int i = 0; i < N; i++) begin
            amem[i] = rnd_val();
            bmem[i] = rnd_val();
        end
    endtask

    task automatic load_sat();
        for (int i = 0; i < N; i++) begin
            amem[i] = '0;
            bmem[i] = '0;
        end
        amem[0] = 32'h7fffffff;
        bmem[0] = 32'hffffffff;
        amem[1] = 32'h80000000;
        bmem[1] = 32'h00000001;
    endtask

    task automatic check_writes(input logic [1:0] md);
        int es;
        bit s;
        logic [31:0] e;
        es = 0;
        chk("wr_count", 64'(wa.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            e = ref_r(md, amem[i], bmem[i], s);
            es += int'(s);
            if (i < wa.size()) begin
                chk("wr_addr", 64'(wa[i]), 64'(i));
                chk("wr_data", 64'(wd[i]), 64'(e));
            end
        end
        chk("sat_count", 64'(m.sat_count), 64'(es));
        chk("sat_any", 64'(m.sat_any), 64'(es != 0));
    endtask

    // Entered at the negedge of the first RUN cycle.
    task automatic finish_call(input logic [1:0] md, input bit toggle);
        int k;
        k = 1;
        while (!m.ap_done && k < N + 10) begin
            if (toggle) m.op_mode = m.op_mode + 2'd1;
            @(negedge clk);
            k++;
        end
        chk("done_latency", 64'(k), 64'(N + 1));
        chk("ready_with_done", 64'(m.ap_ready), 64'(1));
        @(negedge clk);
        chk("done_pulse", 64'(m.ap_done), 64'(0));
        check_writes(md);
    endtask

    task automatic do_call(input logic [1:0] md, input bit toggle,
                           input bit hold);
        wa.delete();
        wd.delete();
        @(negedge clk);
        m.ap_start = 1'b1;
        m.op_mode  = md;
        @(negedge clk);
        if (!hold) m.ap_start = 1'b0;
        finish_call(md, toggle);
    endtask

    initial begin
        logic [31:0] exp5 [3];
        logic [1:0] md;
        logic [31:0] e;
        bit s;
        int k;
        int nwe;
        int ndone;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        m.ap_start  = 1'b0;
        m.op_mode   = 2'b00;
        m1.ap_start = 1'b0;
        m1.op_mode  = 2'b00;
        a1 = '0;
        b1 = '0;
        for (int i = 0; i < N; i++) begin
            amem[i] = '0;
            bmem[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_idle", 64'(m.ap_idle), 64'(1));
        chk("rst_done", 64'(m.ap_done), 64'(0));
        chk("rst_ready", 64'(m.ap_ready), 64'(0));
        chk("rst_ace", 64'(m.A_ce0), 64'(0));
        chk("rst_bce", 64'(m.B_ce0), 64'(0));
        chk("rst_rwe", 64'(m.R_we0), 64'(0));
        chk("rst_sat", 64'(m.sat_count), 64'(0));
        chk("rst_sat_any", 64'(m.sat_any), 64'(0));
        chk("rst_idle_n1", 64'(m1.ap_idle), 64'(1));
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            amem[i] = 32'(i * 3);
            bmem[i] = 32'(i);
        end
        do_call(2'b00, 1'b0, 1'b0);
        chk("ramp_r23", 64'(wd[23]), 64'(46));

        load_sat();
        do_call(2'b00, 1'b0, 1'b0);
        chk("sat_r0", 64'(wd[0]), 64'h7fffffff);
        chk("sat_r1", 64'(wd[1]), 64'h80000000);
        chk("sat_cnt2", 64'(m.sat_count), 64'(2));

        exp5[0] = 32'h7fffffff;
        exp5[1] = 32'h00000000;
        exp5[2] = 32'h40000000;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N; i++) begin
                amem[i] = '0;
                bmem[i] = '0;
            end
            amem[5] = 32'h40000000;
            bmem[5] = 32'h40000000;
            md = 2'(j + 1);
            do_call(md, 1'b0, 1'b0);
            chk("mode_r5", 64'(wd[5]), 64'(exp5[j]));
        end

        load_rand();
        do_call(2'b01, 1'b1, 1'b0);

        load_sat();
        wa.delete();
        wd.delete();
        @(negedge clk);
        m.ap_start = 1'b1;
        m.op_mode  = 2'b00;
        @(negedge clk);
        m.ap_start = 1'b0;
        k = 1;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("pre_rst_sat", 64'(m.sat_count), 64'(2));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_we", 64'(m.R_we0), 64'(0));
        chk("rst_mid_idle", 64'(m.ap_idle), 64'(1));
        chk("rst_mid_sat", 64'(m.sat_count), 64'(0));
        nwe   = 0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            nwe   += int'(m.R_we0);
            ndone += int'(m.ap_done);
        end
        chk("rst_no_write", 64'(nwe), 64'(0));
        chk("rst_no_done", 64'(ndone), 64'(0));

        load_rand();
        do_call(2'($urandom_range(0, 3)), 1'b0, 1'b0);

        load_rand();
        do_call(2'b01, 1'b0, 1'b1);
        chk("b2b_accept_idle", 64'(m.ap_idle), 64'(0));
        chk("b2b_accept_ce", 64'(m.A_ce0), 64'(0));
        @(negedge clk);
        chk("b2b_run_ce", 64'(m.A_ce0), 64'(1));
        chk("b2b_run_addr", 64'(m.A_address0), 64'(0));
        m.ap_start = 1'b0;
        wa.delete();
        wd.delete();
        finish_call(2'b01, 1'b0);

        repeat (6) begin
            load_rand();
            do_call(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        a1 = 32'h7ffffff0;
        b1 = 32'hffffff00;
        @(negedge clk);
        m1.ap_start = 1'b1;
        m1.op_mode  = 2'b00;
        @(negedge clk);
        m1.ap_start = 1'b0;
        m1.op_mode  = 2'b10;
        k   = 1;
        nwe = 0;
        while (!m1.ap_done && k < 10) begin
            nwe += int'(m1.R_we0);
            @(negedge clk);
            k++;
        end
        chk("n1_latency", 64'(k), 64'(2));
        if (m1.R_we0) begin
            nwe++;
            e = ref_r(2'b00, a1, b1, s);
            chk("n1_addr", 64'(m1.R_address0), 64'(0));
            chk("n1_data", 64'(m1.R_d0), 64'(e));
        end
        chk("n1_writes", 64'(nwe), 64'(1));
        @(negedge clk);
        chk("n1_sat", 64'(m1.sat_count), 64'(1));
        chk("n1_sat_any", 64'(m1.sat_any), 64'(1));
        chk("n1_idle", 64'(m1.ap_idle), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mpc_vaddsub_sat_pipe.md
Name: mpc_vaddsub_sat_pipe

Overview:
- Parametrised, pipelined, element-wise saturating vector add/subtract for the MPC solver datapath.
- Reads operands A[i] and B[i] from two single-port RAMs with 1-cycle read latency, and writes R[i].
- Processes one element per cycle (II=1), with a per-call operation mode and saturation statistics.
- Sits beside the other vector kernels under the solver's ap_start/ap_done sequencer.

Parameters:
- N, 24, vector length (≥1).
- W, 32, two's-complement element width. Fixed-point position is irrelevant; arithmetic is integer on raw bits.
- AW, 5, address width, ≥ max(1, ceil(log2 N)).
- CW, 5, saturation-counter width, ≥ ceil(log2(N+1)).

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ap_start  in  1  request to start a call.
- ap_done  out  1  one-cycle pulse: call complete.
- ap_idle  out  1  block is idle.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- op_mode  in  2  00: A-B, 01: A+B, 10: B-A, 11: copy A. Sampled at start accept.
- A_address0  out  AW  A read address.
- A_ce0  out  1  A read enable.
- A_q0  in  W  A data, valid the cycle after A_ce0.
- B_address0  out  AW  B read address.
- B_ce0  out  1  B read enable.
- B_q0  in  W  B data, valid the cycle after B_ce0.
- R_address0  out  AW  result write address.
- R_ce0  out  1  result enable.
- R_we0  out  1  result write enable.
- R_d0  out  W  result data.
- sat_count  out  CW  number of elements saturated in the last or current call.
- sat_any  out  1  sat_count != 0.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - FSM goes to IDLE; index=0; write-valid=0; sat_count=0; mode reg=00.
  - All ce/we=0; ap_done=ap_ready=0.
  - Addresses and R_d0 are don't-care while their enables are 0.
  - Reset mid-call aborts it: no further R writes and no ap_done.
- FSM states IDLE, RUN, DRAIN.
  - IDLE:
    - ap_idle = ~ap_start.
    - When ap_start=1: latch op_mode, index←0, sat_count←0, go to RUN.
  - RUN:
    - A_ce0=B_ce0=1; A_address0=B_address0=index.
    - index←index+1. When index==N-1 this cycle, go to DRAIN.
  - DRAIN:
    - No reads; the final write occurs.
    - ap_done=ap_ready=1 for exactly this cycle.
    - Next state is IDLE unconditionally. A new ap_start is accepted at the earliest on the following cycle.
- Write stage:
  - A write-valid flag and address register are loaded from each RUN read, so R_address0 equals the index read in the previous cycle.
  - In the cycle after each read: R_ce0=R_we0=1, and R_d0 is computed combinationally from A_q0/B_q0.
  - Writes occur in cycles RUN[2..N] and DRAIN: exactly N writes per call, addresses 0..N-1 in order, no duplicates.
- Latency: the start-accept cycle is T0; RUN is T1..TN; DRAIN (ap_done) is TN+1. Total N+2 cycles in the FSM per call.
- Arithmetic:
  - Sign-extend both operands to W+1 bits and apply the latched mode. Copy mode passes A unchanged and never saturates.
  - Overflow when bits [W] and [W-1] of the W+1-bit result differ.
    - Positive overflow (bit W = 0) → 2^(W-1)-1.
    - Negative overflow (bit W = 1) → -2^(W-1).
    - Otherwise take the low W bits.
  - sat_count increments once per saturated write, and cannot wrap given CW.
  - sat_count holds its value after ap_done until the next start accept.
- op_mode and ap_start changes during RUN/DRAIN are ignored.
- N=1: RUN lasts one cycle; DRAIN performs the single write at address 0.

Test Plan:
- W=32, N=24, mode 00, A[i]=i*3, B[i]=i:
  - R[i]=2i at addresses 0..23 in order.
  - ap_done is high exactly 25 cycles after the start-accept cycle.
  - sat_count=0.
- Mode 00, A[0]=0x7FFFFFFF, B[0]=0xFFFFFFFF; A[1]=0x80000000, B[1]=1; others 0:
  - R[0]=0x7FFFFFFF, R[1]=0x80000000.
  - sat_count=2, sat_any=1.
- Modes 01/10/11 with A[5]=0x40000000, B[5]=0x40000000:
  - 01 gives R[5]=0x7FFFFFFF (saturated).
  - 10 gives 0.
  - 11 gives 0x40000000.
- op_mode toggled every cycle during RUN after starting in mode 01: every result is A+B, confirming the latched mode.
- ap_rst_n driven low at RUN cycle 10:
  - No R_we0 from the next cycle on, no ap_done; ap_idle=1, sat_count=0.
  - A subsequent start completes normally.
- Back-to-back calls with ap_start held high; N=1 build (AW=1, CW=1):
  - Second call accepted one cycle after DRAIN.
  - N=1: exactly one write at address 0, with ap_done 2 cycles after accept.
